// File: rtl/crossbar_pkg.sv
// ============================================================================
//  Module      : crossbar_pkg
//  Description : Shared crossbar constants and the output arbiter state type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crossbar_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_FULL  = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// ============================================================================
//  Module      : rr_arbiter4
//  Description : Four-way round-robin picker; search starts at ptr_i and wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter4
    import crossbar_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    logic [PORT_W-1:0] w_idx;

    // Walk from the farthest offset down so the closest request to ptr_i wins.
    always_comb begin
        gnt_o = '0;
        w_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            w_idx = ptr_i + PORT_W'(i);
            if (req_i[w_idx]) begin
                gnt_o        = '0;
                gnt_o[w_idx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/output_arbiter.sv
// ============================================================================
//  Module      : output_arbiter
//  Description : Per-output-port crossbar arbiter (IDLE/GRANT/FULL) with a
//                registered output word. Optional grant timeout enabled by
//                defining OUTPUT_ARBITER_TIMEOUT_EN (adds err_timeout port).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_arbiter
    import crossbar_pkg::*;
#(
    parameter int WIDTH   = 320,
    parameter int PORT_ID = 0,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       head_valid,
    input  logic [1:0]       head_sel0,
    input  logic [1:0]       head_sel1,
    input  logic [1:0]       head_sel2,
    input  logic [1:0]       head_sel3,
    input  logic [WIDTH:0]   in0,
    input  logic [WIDTH:0]   in1,
    input  logic [WIDTH:0]   in2,
    input  logic [WIDTH:0]   in3,
    output logic [3:0]       grant,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
    ,
    output logic             err_timeout
`endif
);

    localparam logic [PORT_W-1:0] c_PORT = PORT_W'(PORT_ID);

    arb_state_e            state_q, state_d;
    logic [NUM_PORTS-1:0]  grant_q, grant_d;
    logic [PORT_W-1:0]     gidx_q, gidx_d;
    logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                  first_q, first_d;
    logic [WIDTH-1:0]      data_q, data_d;

    logic [NUM_PORTS-1:0]  w_req;
    logic [NUM_PORTS-1:0]  w_win;
    logic [PORT_W-1:0]     w_win_idx;
    logic [WIDTH:0]        w_in_sel;
    logic                  w_capture;
    logic                  w_timeout;

    assign w_req = {head_valid[3] && (head_sel3 == c_PORT),
                    head_valid[2] && (head_sel2 == c_PORT),
                    head_valid[1] && (head_sel1 == c_PORT),
                    head_valid[0] && (head_sel0 == c_PORT)};

    rr_arbiter4 u_rr (
        .req_i (w_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (w_win)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_win[i]) begin
                w_win_idx = PORT_W'(i);
            end
        end
    end

    // Only the granted queue's {valid, payload} is ever looked at.
    always_comb begin
        w_in_sel = '0;
        case (gidx_q)
            2'd0:    w_in_sel = in0;
            2'd1:    w_in_sel = in1;
            2'd2:    w_in_sel = in2;
            default: w_in_sel = in3;
        endcase
    end

    assign w_capture = (state_q == ST_GRANT) && !first_q && w_in_sel[WIDTH];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        first_d  = first_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (|w_req) begin
                    grant_d = w_win;
                    gidx_d  = w_win_idx;
                    first_d = 1'b1;
                    state_d = ST_GRANT;
                end else begin
                    grant_d = '0;
                end
            end
            ST_GRANT: begin
                first_d = 1'b0;
                if (w_capture) begin
                    data_d   = w_in_sel[WIDTH-1:0];
                    grant_d  = '0;
                    rr_ptr_d = gidx_q + 2'd1;
                    state_d  = ST_FULL;
                end else if (w_timeout) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            first_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            first_q  <= first_d;
            data_q   <= data_d;
        end
    end

`ifdef OUTPUT_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // cnt_q holds the number of completed GRANT cycles for the current grant.
    assign w_timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ST_GRANT && state_d == ST_GRANT) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            err_q <= (state_q == ST_GRANT) && !w_capture && w_timeout;
        end
    end

    assign err_timeout = err_q;
`else
    assign w_timeout = 1'b0;
`endif

    assign grant     = grant_q;
    assign out_data  = data_q;
    assign out_valid = (state_q == ST_FULL);

endmodule

`default_nettype wire

// File: tb/tb_output_arbiter.sv
// ============================================================================
//  Module      : tb_output_arbiter
//  Description : Directed self-checking bench for output_arbiter (PORT_ID=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [3:0]   head_valid;
    logic [1:0]   head_sel0, head_sel1, head_sel2, head_sel3;
    logic [W:0]   in0, in1, in2, in3;
    logic [3:0]   grant;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
    logic         err_timeout;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    output_arbiter #(.WIDTH(W), .PORT_ID(2), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .head_valid (head_valid),
        .head_sel0  (head_sel0),
        .head_sel1  (head_sel1),
        .head_sel2  (head_sel2),
        .head_sel3  (head_sel3),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .grant      (grant),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
        ,
        .err_timeout(err_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        head_valid = 4'b0101;
        head_sel0 = 2'd2; head_sel1 = 2'd1; head_sel2 = 2'd2; head_sel3 = 2'd2;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_tests++;
        if (out_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h expected 00", out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        tick();
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL basic_grant: got %b expected 0001", grant);
        end
        in0 = {1'b1, 8'hA5};
        tick();
        n_tests++;
        if (grant !== 4'b0001 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_first_ignore: got grant %b valid %b expected 0001 0", grant, out_valid);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            n_fail++; $display("FAIL basic_capture: got valid %b data %h expected 1 a5", out_valid, out_data);
        end
        n_tests++;
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL basic_grant_clear: got %b expected 0000", grant);
        end
        in0 = '0;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (out_data !== 8'hA5 || out_valid !== 1'b1 || grant !== 4'b0000) begin
                n_fail++; $display("FAIL hold_%0d: got data %h valid %b grant %b expected a5 1 0000", i, out_data, out_valid, grant);
            end
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || grant !== 4'b0000) begin
            n_fail++; $display("FAIL hold_release: got valid %b grant %b expected 0 0000", out_valid, grant);
        end
        out_ready = 1'b0;
        tick();
        n_tests++;
        if (grant !== 4'b0100) begin
            n_fail++; $display("FAIL hold_next_rr: got %b expected 0100", grant);
        end
    endtask

    task automatic test_ignore_other();
        in0 = {1'b1, 8'h77};
        in1 = {1'b1, 8'h66};
        head_valid = 4'b0001;
        head_sel2 = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (grant !== 4'b0100 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL ignore_%0d: got grant %b valid %b expected 0100 0", i, grant, out_valid);
            end
        end
        in0 = '0; in1 = '0;
        in2 = {1'b1, 8'h3C};
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            n_fail++; $display("FAIL ignore_capture: got valid %b data %h expected 1 3c", out_valid, out_data);
        end
        in2 = '0;
        head_valid = 4'b0101;
        head_sel2 = 2'd2;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL ignore_wrap: got %b expected 0001", grant);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        n_tests++;
        if (grant !== 4'b0000 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_grant_state: got grant %b valid %b data %h expected 0000 0 00", grant, out_valid, out_data);
        end
        rst = 1'b0;
        tick();
        in0 = {1'b1, 8'h5A};
        tick();
        tick();
        in0 = '0;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            n_fail++; $display("FAIL rst_setup_full: got valid %b data %h expected 1 5a", out_valid, out_data);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (grant !== 4'b0000 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_full_state: got grant %b valid %b data %h expected 0000 0 00", grant, out_valid, out_data);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL rst_ptr_cleared: got %b expected 0001", grant);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g [3];
        logic [7:0] exp_d [3];
        logic [3:0] prev;
        int ng;
        int nd;
        exp_g = '{4'b0001, 4'b0100, 4'b0001};
        exp_d = '{8'h11, 8'h22, 8'h11};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in0 = {1'b1, 8'h11};
        in2 = {1'b1, 8'h22};
        out_ready = 1'b1;
        prev = 4'b0000;
        ng = 0;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (grant !== 4'b0000 && prev === 4'b0000 && ng < 3) begin
                n_tests++;
                if (grant !== exp_g[ng]) begin
                    n_fail++; $display("FAIL b2b_grant_%0d: got %b expected %b", ng, grant, exp_g[ng]);
                end
                ng++;
            end
            if (out_valid === 1'b1 && nd < 3) begin
                n_tests++;
                if (out_data !== exp_d[nd]) begin
                    n_fail++; $display("FAIL b2b_data_%0d: got %h expected %h", nd, out_data, exp_d[nd]);
                end
                nd++;
            end
            prev = grant;
        end
        n_tests++;
        if (ng != 3 || nd != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d grants %0d words expected 3 3", ng, nd);
        end
        in0 = '0; in2 = '0;
        out_ready = 1'b0;
    endtask

`ifdef OUTPUT_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_tests++;
            if (grant !== 4'b0001 || err_timeout !== 1'b0) begin
                n_fail++; $display("FAIL tmo_wait_%0d: got grant %b err %b expected 0001 0", i, grant, err_timeout);
            end
        end
        tick();
        n_tests++;
        if (grant !== 4'b0000 || err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL tmo_fire: got grant %b err %b expected 0000 1", grant, err_timeout);
        end
        tick();
        n_tests++;
        if (grant !== 4'b0001 || err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL tmo_after: got grant %b err %b expected 0001 0", grant, err_timeout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_ignore_other();
        test_reset_mid();
        test_back_to_back();
`ifdef OUTPUT_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
